// File: rtl/fp32_mul_sched.sv
// fp32_mul_sched: round-robin scheduler sharing one pipelined FP32
// multiplier between requesters, with a credit-guarded response FIFO.
module fp32_mul_sched #(
  parameter int N_REQ     = 4,
  parameter int MUL_LAT   = 6,
  parameter int RSP_DEPTH = 8,
  parameter int ID_W      = $clog2(N_REQ)
) (
  input  logic                clkn_i,
  input  logic                rstn_i,
  input  logic [N_REQ-1:0]    req_valid_i,
  input  logic [32*N_REQ-1:0] req_a_i,
  input  logic [32*N_REQ-1:0] req_b_i,
  output logic [N_REQ-1:0]    req_ready_o,
  output logic [31:0]         mul_a_o,
  output logic [31:0]         mul_b_o,
  input  logic [31:0]         mul_res_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [31:0]         rsp_data_o,
  output logic [ID_W-1:0]     rsp_id_o,
  output logic                busy_o
);

  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam logic [CW-1:0] CRD_MAX = CW'(RSP_DEPTH);
  localparam logic [PW:0] CNT_MAX = (PW+1)'(RSP_DEPTH);

  logic [ID_W-1:0]    rr_q;
  logic [CW-1:0]      crd_q;
  logic [CW-1:0]      crd_d;
  logic [31:0]        mul_a_q;
  logic [31:0]        mul_b_q;
  logic [MUL_LAT-1:0] tv_q;
  logic [MUL_LAT-1:0] tv_d;
  logic [ID_W-1:0]    tid_q [MUL_LAT];

  logic [31:0]        fd_q [RSP_DEPTH];
  logic [ID_W-1:0]    fi_q [RSP_DEPTH];
  logic [PW-1:0]      wp_q;
  logic [PW-1:0]      rp_q;
  logic [PW:0]        cnt_q;

  logic [N_REQ-1:0]   gnt;
  logic [ID_W-1:0]    gid;
  logic [ID_W-1:0]    idx;
  logic [31:0]        sel_a;
  logic [31:0]        sel_b;
  logic               issue;
  logic               pop;
  logic               wr;
  logic               can_issue;

  assign rsp_valid_o = (cnt_q != '0);
  assign pop         = rsp_valid_o & rsp_ready_i;
  assign wr          = tv_q[MUL_LAT-1];
  // a pop this cycle frees a slot the new op may claim
  assign can_issue   = (crd_q != '0) | pop;

  always_comb begin
    gnt = '0;
    gid = rr_q;
    idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = ID_W'((int'(rr_q) + k) % N_REQ);
      if (can_issue && gnt == '0 && req_valid_i[idx]) begin
        gnt[idx] = 1'b1;
        gid      = idx;
      end
    end
  end

  assign issue       = |gnt;
  assign req_ready_o = gnt;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        sel_a = req_a_i[32*i +: 32];
        sel_b = req_b_i[32*i +: 32];
      end
    end
  end

  always_comb begin
    crd_d = crd_q;
    unique case ({issue, pop})
      2'b10:   crd_d = crd_q - 1'b1;
      2'b01:   crd_d = crd_q + 1'b1;
      default: crd_d = crd_q;
    endcase
  end

  assign tv_d = MUL_LAT'({tv_q, issue});

  always_ff @(negedge clkn_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rr_q    <= ID_W'(N_REQ - 1);
      crd_q   <= CRD_MAX;
      mul_a_q <= '0;
      mul_b_q <= '0;
      tv_q    <= '0;
    end else begin
      crd_q <= crd_d;
      tv_q  <= tv_d;
      if (issue) begin
        rr_q    <= gid;
        mul_a_q <= sel_a;
        mul_b_q <= sel_b;
      end else begin
        mul_a_q <= '0;
        mul_b_q <= '0;
      end
    end
  end

  // ids ride alongside the valid bits; stale ids behind a 0 valid are inert
  always_ff @(negedge clkn_i) begin
    tid_q[0] <= gid;
    for (int k = 1; k < MUL_LAT; k++) begin
      tid_q[k] <= tid_q[k-1];
    end
  end

  always_ff @(negedge clkn_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      assert (!(wr && cnt_q == CNT_MAX));
      if (wr) begin
        wp_q <= wp_q + 1'b1;
      end
      if (pop) begin
        rp_q <= rp_q + 1'b1;
      end
      cnt_q <= cnt_q + (PW+1)'(wr) - (PW+1)'(pop);
    end
  end

  always_ff @(negedge clkn_i) begin
    if (wr) begin
      fd_q[wp_q] <= mul_res_i;
      fi_q[wp_q] <= tid_q[MUL_LAT-1];
    end
  end

  assign rsp_data_o = fd_q[rp_q];
  assign rsp_id_o   = fi_q[rp_q];
  assign mul_a_o    = mul_a_q;
  assign mul_b_o    = mul_b_q;
  assign busy_o     = (|tv_q) | rsp_valid_o;

endmodule

// File: tb/tb_fp32_mul_sched.sv
// Bench for fp32_mul_sched: model multiplier, grant/response scoreboard,
// vector table plus directed credit, backpressure and reset sequences.
module tb_fp32_mul_sched;

  localparam int N     = 4;
  localparam int LAT   = 6;
  localparam int DEPTH = 8;

  logic            clkn_i = 1'b1;
  logic            rstn_i;
  logic [N-1:0]    req_valid_i;
  logic [32*N-1:0] req_a_i;
  logic [32*N-1:0] req_b_i;
  logic [N-1:0]    req_ready_o;
  logic [31:0]     mul_a_o;
  logic [31:0]     mul_b_o;
  logic [31:0]     mul_res_i;
  logic            rsp_valid_o;
  logic            rsp_ready_i;
  logic [31:0]     rsp_data_o;
  logic [1:0]      rsp_id_o;
  logic            busy_o;

  fp32_mul_sched #(
    .N_REQ(N), .MUL_LAT(LAT), .RSP_DEPTH(DEPTH)
  ) dut (
    .clkn_i(clkn_i), .rstn_i(rstn_i),
    .req_valid_i(req_valid_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
    .req_ready_o(req_ready_o),
    .mul_a_o(mul_a_o), .mul_b_o(mul_b_o), .mul_res_i(mul_res_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_id_o(rsp_id_o), .busy_o(busy_o)
  );

  always #5 clkn_i = ~clkn_i;

  int checks = 0;
  int failures = 0;

  task automatic chk(input bit ok, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // truncating FP32 multiply for normal operands, zero otherwise
  function automatic logic [31:0] mul_fn(input logic [31:0] a,
                                         input logic [31:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    logic [22:0] m;
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0)
      return {a[31] ^ b[31], 31'b0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 10'd1;
    end else begin
      m = p[45:23];
    end
    return {a[31] ^ b[31], e[7:0], m};
  endfunction

  logic [31:0] mp [LAT-1];
  always @(negedge clkn_i) begin
    mp[0] <= mul_fn(mul_a_o, mul_b_o);
    for (int k = 1; k < LAT - 1; k++) mp[k] <= mp[k-1];
  end
  assign mul_res_i = mp[LAT-2];

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  id;
  } sb_t;

  sb_t sb [$];
  int  glog [$];
  int  rr_m;
  int  nissue = 0;
  int  npop = 0;
  int  jm;
  bit  pop_m;
  logic [N-1:0] exp_g;
  sb_t e_m;

  always @(posedge clkn_i) begin
    #1;
    if (!rstn_i) begin
      sb.delete();
      glog.delete();
      rr_m = N - 1;
    end else begin
      pop_m = rsp_valid_o & rsp_ready_i;
      exp_g = '0;
      if (sb.size() < DEPTH || pop_m) begin
        for (int k = 1; k <= N; k++) begin
          jm = (rr_m + k) % N;
          if (exp_g == '0 && req_valid_i[jm]) exp_g[jm] = 1'b1;
        end
      end
      chk(req_ready_o == exp_g, "arb_grant", 32'(req_ready_o), 32'(exp_g));
      if (pop_m) begin
        if (sb.size() == 0) begin
          chk(1'b0, "rsp_unexpected", rsp_data_o, 32'h0);
        end else begin
          e_m = sb.pop_front();
          chk(rsp_data_o == e_m.d, "rsp_data", rsp_data_o, e_m.d);
          chk(rsp_id_o == e_m.id, "rsp_id", 32'(rsp_id_o), 32'(e_m.id));
          npop++;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid_i[i] && req_ready_o[i]) begin
          sb.push_back({mul_fn(req_a_i[32*i +: 32], req_b_i[32*i +: 32]),
                        2'(i)});
          glog.push_back(i);
          rr_m = i;
          nissue++;
        end
      end
    end
  end

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [6];
  logic [31:0] ops [6];

  task automatic do_reset();
    @(posedge clkn_i);
    rstn_i = 1'b0;
    req_valid_i = '0;
    repeat (2) @(posedge clkn_i);
    rstn_i = 1'b1;
  endtask

  task automatic run_one(input vec_t v);
    int  k;
    bit  seen;
    @(posedge clkn_i);
    req_valid_i = '0;
    req_valid_i[v.id] = 1'b1;
    req_a_i[32*v.id +: 32] = v.a;
    req_b_i[32*v.id +: 32] = v.b;
    #1;
    chk(req_ready_o == req_valid_i, "vec_grant",
        32'(req_ready_o), 32'(req_valid_i));
    @(negedge clkn_i);
    #1;
    req_valid_i = '0;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 20) begin
      @(negedge clkn_i);
      #1;
      k++;
      seen = rsp_valid_o;
    end
    chk(seen && k == LAT, "vec_latency", k, LAT);
    chk(rsp_data_o == v.exp, "vec_data", rsp_data_o, v.exp);
    chk(rsp_id_o == 2'(v.id), "vec_id", 32'(rsp_id_o), v.id);
    repeat (2) @(negedge clkn_i);
    #1;
    chk(busy_o == 1'b0, "vec_idle", 32'(busy_o), 0);
  endtask

  task automatic drain(input int bound, input string name);
    int k;
    k = 0;
    while ((busy_o || sb.size() != 0) && k < bound) begin
      @(posedge clkn_i);
      #2;
      k++;
    end
    chk(k < bound, name, k, bound);
  endtask

  initial begin
    int  base;
    int  p0;
    bit  bad;
    vt[0] = '{0, 32'h40000000, 32'h40400000, 32'h40C00000};
    vt[1] = '{1, 32'h00000000, 32'h3F800000, 32'h00000000};
    vt[2] = '{2, 32'h3F800000, 32'h3F800000, 32'h3F800000};
    vt[3] = '{3, 32'hC0000000, 32'h3F000000, 32'hBF800000};
    vt[4] = '{1, 32'h3FC00000, 32'h3FC00000, 32'h40100000};
    vt[5] = '{2, 32'h40800000, 32'h3E800000, 32'h3F800000};
    ops = '{32'h40000000, 32'h40400000, 32'h3F800000,
            32'hC0000000, 32'h3FC00000, 32'h3E800000};

    rstn_i = 1'b0;
    req_valid_i = '0;
    req_a_i = '0;
    req_b_i = '0;
    rsp_ready_i = 1'b1;
    #1;
    chk(rsp_valid_o == 1'b0, "rst_rsp_valid", 32'(rsp_valid_o), 0);
    chk(busy_o == 1'b0, "rst_busy", 32'(busy_o), 0);
    chk(req_ready_o == '0, "rst_ready", 32'(req_ready_o), 0);
    chk(mul_a_o == '0 && mul_b_o == '0, "rst_mul_ops", mul_a_o, 0);
    repeat (2) @(posedge clkn_i);
    rstn_i = 1'b1;

    foreach (vt[i]) run_one(vt[i]);

    bad = 1'b0;
    repeat (10) begin
      @(negedge clkn_i);
      #1;
      if (rsp_valid_o || busy_o) bad = 1'b1;
    end
    chk(!bad, "bubble_no_rsp", 32'(bad), 0);

    do_reset();
    base = nissue;
    for (int c = 0; c < 20; c++) begin
      @(posedge clkn_i);
      req_valid_i = '1;
      for (int i = 0; i < N; i++) begin
        req_a_i[32*i +: 32] = ops[$urandom_range(0, 5)];
        req_b_i[32*i +: 32] = ops[$urandom_range(0, 5)];
      end
    end
    @(posedge clkn_i);
    req_valid_i = '0;
    #2;
    chk(nissue - base == 20, "t2_issue_rate", nissue - base, 20);
    chk(glog.size() >= 8, "t2_log_len", glog.size(), 8);
    for (int k = 0; k < 8; k++) begin
      if (k < glog.size())
        chk(glog[k] == k % N, "t2_rr_order", glog[k], k % N);
    end
    drain(40, "t2_drain");

    rsp_ready_i = 1'b0;
    base = nissue;
    for (int c = 0; c < 16; c++) begin
      @(posedge clkn_i);
      req_valid_i = 4'b0010;
      req_a_i[63:32] = ops[c % 6];
      req_b_i[63:32] = ops[(c + 2) % 6];
    end
    @(posedge clkn_i);
    #1;
    chk(nissue - base == DEPTH, "t3_accepted", nissue - base, DEPTH);
    chk(req_ready_o == '0, "t3_blocked", 32'(req_ready_o), 0);
    chk(rsp_valid_o && busy_o, "t3_full_valid", 32'(rsp_valid_o), 1);
    req_valid_i = '0;
    p0 = npop;
    @(posedge clkn_i);
    rsp_ready_i = 1'b1;
    drain(40, "t3_drain");
    chk(npop - p0 == DEPTH, "t3_popped", npop - p0, DEPTH);

    rsp_ready_i = 1'b0;
    p0 = npop;
    for (int c = 0; c < 16; c++) begin
      @(posedge clkn_i);
      req_valid_i = 4'b0100;
      req_a_i[95:64] = ops[(c + 1) % 6];
      req_b_i[95:64] = ops[c % 6];
    end
    @(posedge clkn_i);
    rsp_ready_i = 1'b1;
    #1;
    chk(req_ready_o == 4'b0100, "t4_pop_issue", 32'(req_ready_o), 32'h4);
    @(posedge clkn_i);
    rsp_ready_i = 1'b0;
    #1;
    chk(req_ready_o == '0, "t4_credit_zero", 32'(req_ready_o), 0);
    @(posedge clkn_i);
    req_valid_i = '0;
    rsp_ready_i = 1'b1;
    drain(40, "t4_drain");
    chk(npop - p0 == DEPTH + 1, "t4_popped", npop - p0, DEPTH + 1);

    rsp_ready_i = 1'b0;
    @(posedge clkn_i);
    req_valid_i = 4'b0001;
    req_a_i[31:0] = 32'h40000000;
    req_b_i[31:0] = 32'h40400000;
    repeat (2) @(posedge clkn_i);
    req_valid_i = '0;
    repeat (6) @(posedge clkn_i);
    req_valid_i = 4'b0100;
    req_a_i[95:64] = 32'h3FC00000;
    req_b_i[95:64] = 32'h40000000;
    repeat (3) @(posedge clkn_i);
    req_valid_i = '0;
    #2;
    chk(sb.size() == 5, "t5_outstanding", sb.size(), 5);
    chk(mul_a_o != '0, "t5_pre_mul_a", mul_a_o, 32'h3FC00000);
    rstn_i = 1'b0;
    #1;
    chk(rsp_valid_o == 1'b0, "t5_rsp_valid", 32'(rsp_valid_o), 0);
    chk(busy_o == 1'b0, "t5_busy", 32'(busy_o), 0);
    chk(mul_a_o == '0, "t5_mul_a", mul_a_o, 0);
    repeat (2) @(posedge clkn_i);
    rstn_i = 1'b1;
    rsp_ready_i = 1'b1;
    run_one('{3, 32'h40800000, 32'h3E800000, 32'h3F800000});
    repeat (10) @(posedge clkn_i);
    #2;
    chk(!busy_o && sb.size() == 0, "t5_clean", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
